// File: rtl/id_operand_stage.sv
// Decode-stage pipeline slot: holds one instruction, resolves source operands via
// prioritised forwarding with load-use interlock. Optional stall counter: ID_STALL_CNT_EN.
module id_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [31:0]               in_inst,
    output logic                      id_allow_in,
    input  logic                      flush,
    input  logic                      hold,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_inst,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    output logic [NUM_SRC*XLEN-1:0]   opnd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               stall_cnt
);

    logic                             valid_q;
    logic [XLEN-1:0]                  pc_q;
    logic [31:0]                      inst_q;
    logic [NUM_SRC-1:0]               cap_q;
    logic [NUM_SRC-1:0][XLEN-1:0]     cap_data_q;

    logic [NUM_SRC-1:0]               res;
    logic [NUM_SRC-1:0]               fwd_hit;
    logic [NUM_SRC-1:0]               can_cap;
    logic [NUM_SRC-1:0][XLEN-1:0]     opnd;
    logic                             ready_go;
    logic                             issue;
    logic                             load;

    // Per-source resolution: x0, captured value, youngest matching producer, register file.
    // can_cap marks values that came from live sources and may be latched this cycle.
    always_comb begin
        res     = '0;
        fwd_hit = '0;
        can_cap = '0;
        opnd    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_addr[k*REG_AW +: REG_AW] == '0) begin
                res[k]  = 1'b1;
                opnd[k] = '0;
            end else if (cap_q[k]) begin
                res[k]  = 1'b1;
                opnd[k] = cap_data_q[k];
            end else begin
                for (int i = 0; i < NUM_FWD; i++) begin
                    if (!fwd_hit[k] && fwd_valid[i] && fwd_we[i] &&
                        fwd_addr[i*REG_AW +: REG_AW] == src_addr[k*REG_AW +: REG_AW]) begin
                        fwd_hit[k] = 1'b1;
                        res[k]     = fwd_rdy[i];
                        opnd[k]    = fwd_data[i*XLEN +: XLEN];
                    end
                end
                if (!fwd_hit[k]) begin
                    res[k]  = 1'b1;
                    opnd[k] = rf_rdata[k*XLEN +: XLEN];
                end
                can_cap[k] = res[k];
            end
        end
    end

    // Handshake: out_valid/out_ready transfer when both high; id_allow_in/in_valid
    // transfer when both high. out_valid does not depend on out_ready.
    assign ready_go    = !hold && ((src_en & ~res) == '0);
    assign out_valid   = valid_q && ready_go;
    assign issue       = out_valid && out_ready;
    assign id_allow_in = !valid_q || (ready_go && out_ready);
    assign load        = in_valid && id_allow_in;

    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign opnd_data = opnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            cap_q      <= '0;
            cap_data_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            cap_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            inst_q  <= in_inst;
            cap_q   <= '0;
        end else if (issue) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Latch resolved operands so a downstream stall cannot lose a forwarded value.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (src_en[k] && can_cap[k]) begin
                    cap_q[k]      <= 1'b1;
                    cap_data_q[k] <= opnd[k];
                end
            end
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !hold && ((src_en & ~res) != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-stage pipeline slot with generic operand bypass and load-use interlock. It sits between the fetch and execute stages. It holds one instruction (pc, inst) behind a valid/allow-in handshake and resolves NUM_SRC source operands against NUM_FWD prioritised producer stages. Operands that have been resolved are latched while the slot waits, so a downstream stall can never lose a forwarded value.

## Interface

**Parameters**
- XLEN, 32: datapath width.
- NUM_SRC, 2: number of source operands.
- NUM_FWD, 3: number of producer stages. Index 0 is the youngest (EX) and has the highest priority; index NUM_FWD-1 must be the stage that writes the register file.
- REG_AW, 5: register address width.

**Ports** (one clock; reset is asynchronous and active-high)
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- in_valid, in, 1: upstream holds a valid instruction.
- in_pc, in, XLEN: upstream pc.
- in_inst, in, 32: upstream instruction.
- id_allow_in, out, 1: slot accepts upstream this cycle.
- flush, in, 1: branch/exception cancel.
- hold, in, 1: controller hold; blocks issue.
- out_pc, out, XLEN: held pc.
- out_inst, out, 32: held instruction, fed to the external decoder.
- src_en, in, NUM_SRC: decoder says source k is used.
- src_addr, in, NUM_SRC*REG_AW: source register addresses.
- rf_rdata, in, NUM_SRC*XLEN: register-file read data.
- fwd_valid, in, NUM_FWD: producer stage valid.
- fwd_we, in, NUM_FWD: producer writes a register.
- fwd_addr, in, NUM_FWD*REG_AW: producer destination register.
- fwd_data, in, NUM_FWD*XLEN: producer result.
- fwd_rdy, in, NUM_FWD: producer result is available this cycle (0 for a load still in EX).
- opnd_data, out, NUM_SRC*XLEN: resolved operands.
- out_valid, out, 1: slot issues to EX.
- out_ready, in, 1: EX allow-in.
- stall_cnt, out, 32: interlock stall-cycle count.

## Operation

**Slot control**
- State: `valid`, `pc`, `inst`, `cap[NUM_SRC]`, `cap_data[NUM_SRC]`.
- `ready_go = !hold && all k: (!src_en[k] || res[k])`.
- `id_allow_in = !valid || (ready_go && out_ready)`.
- `out_valid = valid && ready_go`.
- Load: if `in_valid && id_allow_in`, then `pc`/`inst` are loaded, `valid` is set to 1, and `cap` is cleared.
- If the slot issues with no new input, `valid` goes to 0.

**Source k resolution** (the first matching rule wins)
1. `src_addr == 0`: value is 0, resolved.
2. `cap[k]`: value is `cap_data[k]`, resolved.
3. Lowest index i with `fwd_valid[i] && fwd_we[i] && fwd_addr[i] == src_addr`:
   - if `fwd_rdy[i]`: value is `fwd_data[i]`, resolved;
   - else: unresolved (interlock).
   - Lower-priority matches are ignored.
4. Otherwise: value is `rf_rdata[k]`, resolved.

**Capture**
- Each cycle the slot is valid, is not issuing, and source k is resolved via rule 3 or 4, set `cap[k]` and latch the value.
- Source k is never recaptured while `cap[k]` is set.
- `src_en`-gated: a disabled source is never captured and never interlocks.

**Flush**
- `flush` forces `valid` to 0 and clears `cap` on the next edge.
- Flush has priority over a simultaneous load; the incoming instruction is dropped.
- Flush is ignored on an empty slot, apart from clearing `cap`.

## Timing

- Reset values:
  - `valid` = 0, so `out_valid` = 0 and `id_allow_in` = 1.
  - `pc`, `inst`, `cap_data` = 0; `cap` = 0; `stall_cnt` = 0.
- Latency: an instruction accepted at edge N is presented at N+1. It issues in the same cycle if it is resolved and `out_ready` is high.
- Back-to-back: with no hazards, one instruction per cycle.
- Load-use: a producer with `fwd_rdy=0` stalls the slot for exactly as many cycles as `fwd_rdy` stays low. When the producer advances to a ready stage, the slot resolves in that cycle.
- `hold` high: `out_valid` = 0. Capture continues.
- Reset asserted mid-stall: the slot empties immediately (asynchronous).
- All operand paths are combinational; only the slot state and capture are registered.

## Configuration

- `ID_STALL_CNT_EN` defined: `stall_cnt` increments each cycle that `valid && !hold` and some enabled source is unresolved. It saturates at 0xFFFFFFFF and is cleared only by `rst`.
- `ID_STALL_CNT_EN` undefined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan

- **Independent stream.** 4 instructions, `src_addr` 1/2, no forward matches, `rf_rdata` 0x11/0x22 → `out_valid` every cycle from cycle 1, `opnd_data` = {0x22, 0x11}.
- **Priority.** `fwd_addr[0]` = `fwd_addr[2]` = 5 with data 0xA / 0xC, both ready, `src_addr` = 5 → operand 0xA. Repeat with `src_addr` = 0 → operand 0.
- **Load-use.** `fwd[0]` matches with `fwd_rdy=0` for 1 cycle, then the producer moves to `fwd[1]` with `fwd_rdy=1` and data 0x55 → one stall cycle, then issue with 0x55. `stall_cnt` = 1 when the macro is defined, 0 when it is not.
- **Capture under downstream stall.** Source resolved from `fwd[2]` = 0x77, `out_ready=0` for 3 cycles while `fwd[2]` is deasserted → issue still carries 0x77.
- **Flush.** `flush` together with `in_valid` while a stalled instruction is held → next cycle `valid`=0, `out_valid`=0, `id_allow_in`=1, and the incoming instruction is not presented.
- **Reset mid-stall.** Assert `rst` asynchronously → `out_valid`=0 and `stall_cnt`=0 immediately, without waiting for a clock edge.
